// File: rtl/f_pc_reg.sv
// Fetch-stage PC register: latches next-PC, redirects to the exception handler,
// tags branch-delay slots, flags illegal fetch addresses and counts fetch/exception events.
module f_pc_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFF,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        D_is_jump,
  output logic [31:0] F_PC,
  output logic        F_bd,
  output logic        F_exc,
  output logic [4:0]  F_exc_code,
  output logic [31:0] F_fetch_cnt,
  output logic [15:0] F_exc_cnt
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] exc_cnt_q, exc_cnt_d;
  logic        adel;

  // Redirect beats stall; a stalled cycle holds every register.
  always_comb begin
    pc_d        = pc_q;
    bd_d        = bd_q;
    fetch_cnt_d = fetch_cnt_q;
    exc_cnt_d   = exc_cnt_q;
    if (req) begin
      pc_d = HANDLER_PC;
      bd_d = 1'b0;
      if (exc_cnt_q != 16'hFFFF) begin
        exc_cnt_d = exc_cnt_q + 16'd1;
      end
    end else if (!stall) begin
      pc_d        = npc;
      bd_d        = D_is_jump;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      bd_q        <= 1'b0;
      fetch_cnt_q <= 32'd0;
      exc_cnt_q   <= 16'd0;
    end else begin
      pc_q        <= pc_d;
      bd_q        <= bd_d;
      fetch_cnt_q <= fetch_cnt_d;
      exc_cnt_q   <= exc_cnt_d;
    end
  end

  always_comb begin
    adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
  end

  assign F_PC        = pc_q;
  assign F_bd        = bd_q;
  assign F_exc       = adel;
  assign F_exc_code  = adel ? EXC_ADEL : 5'd0;
  assign F_fetch_cnt = fetch_cnt_q;
  assign F_exc_cnt   = exc_cnt_q;

endmodule
